gate_op_arbiter: RTL and testbench

//  Shares one bitwise logic-op unit (OR/AND/XOR/XNOR/NAND/NOR/ADD) between NREQ requesters.

---
 rtl/gate_op_arbiter.sv | 115 +++++++++++
 tb/tb_gate_op_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise/add logic-op unit between NREQ requesters,
// with a single registered result slot drained through a valid/ready handshake.
module gate_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*3-1:0]       req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_err,
    output logic [15:0]             op_count
);

    logic [IDW-1:0]   r_ptr;
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_data_p1;
    logic [IDW-1:0]   r_id_p1;
    logic             r_err_p1;
    logic [15:0]      r_op_count;

    logic             w_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic             w_slot_free;
    logic             w_accept;

    function automatic logic [WIDTH-1:0] f_logic_op(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [2:0]       op);
        logic [WIDTH-1:0] res;
        case (op)
            3'd0:    res = a | b;
            3'd1:    res = a & b;
            3'd2:    res = a ^ b;
            3'd3:    res = ~(a ^ b);
            3'd4:    res = ~(a & b);
            3'd5:    res = ~(a | b);
            3'd6:    res = a + b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Stage p0: arbitration. Lowest valid index overall is the wrap-around fallback;
    // the lowest valid index at or above the pointer overrides it.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= r_ptr)) begin
                w_gnt_idx = IDW'(i);
            end
        end
    end

    assign w_a         = req_a[w_gnt_idx*WIDTH +: WIDTH];
    assign w_b         = req_b[w_gnt_idx*WIDTH +: WIDTH];
    assign w_op        = req_op[w_gnt_idx*3 +: 3];
    assign w_slot_free = !r_vld_p1 || rsp_ready;
    assign w_accept    = rst_n && w_found && w_slot_free;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Stage p1: result register, refilled in the same cycle it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_id_p1    <= '0;
            r_err_p1   <= 1'b0;
            r_op_count <= '0;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_data_p1  <= f_logic_op(w_a, w_b, w_op);
            r_id_p1    <= w_gnt_idx;
            r_err_p1   <= (w_op == 3'd7);
            r_ptr      <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end else if (rsp_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign rsp_valid = r_vld_p1;
    assign rsp_data  = r_data_p1;
    assign rsp_id    = r_id_p1;
    assign rsp_err   = r_err_p1;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the arbiter.
module tb_gate_op_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;
    logic [15:0]           op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] calc(input int a, input int b, input int op);
        int m;
        m = (1 << WIDTH) - 1;
        case (op)
            0: return WIDTH'(a | b);
            1: return WIDTH'(a & b);
            2: return WIDTH'(a ^ b);
            3: return WIDTH'(m - (a ^ b));
            4: return WIDTH'(m - (a & b));
            5: return WIDTH'(m - (a | b));
            6: return WIDTH'((a + b) % (1 << WIDTH));
            default: return '0;
        endcase
    endfunction

    logic             m_vld;
    logic [WIDTH-1:0] m_data;
    int               m_id;
    logic             m_err;
    int               m_cnt;
    int               m_ptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_id   <= 0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
            m_ptr  <= 0;
        end else begin
            automatic int g = pick(req_valid, m_ptr);
            if ((!m_vld || rsp_ready) && g >= 0) begin
                m_vld  <= 1'b1;
                m_data <= calc(int'(req_a[g*WIDTH +: WIDTH]), int'(req_b[g*WIDTH +: WIDTH]),
                               int'(req_op[g*3 +: 3]));
                m_err  <= (req_op[g*3 +: 3] == 3'd7);
                m_id   <= g;
                m_ptr  <= (g + 1) % NREQ;
                m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end else if (rsp_ready) begin
                m_vld  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        automatic int              g = pick(req_valid, m_ptr);
        automatic logic [NREQ-1:0] exp_rdy = '0;
        if (rst_n && (!m_vld || rsp_ready) && g >= 0) exp_rdy[g] = 1'b1;
        chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("m_op_count",  32'(op_count),  32'(m_cnt));
        chk("m_rsp_data",  32'(rsp_data),  32'(m_data));
        chk("m_rsp_id",    32'(rsp_id),    32'(m_id));
        chk("m_rsp_err",   32'(rsp_err),   32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int               seq1[6] = '{0, 1, 2, 3, 0, 1};
        automatic int               seq2[4] = '{0, 1, 3, 0};
        automatic logic [WIDTH-1:0] sweep[7] = '{8'hBD, 8'h24, 8'h99, 8'h66, 8'hDB, 8'h42, 8'hE1};
        automatic int               guard = 0;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(8'h11 * (i + 1));
            req_b[i*WIDTH +: WIDTH] = WIDTH'(8'h0F << i);
            req_op[i*3 +: 3]        = 3'(i + 3);
        end

        // Reset held with every requester asking
        step();
        chk("t1_rst_req_ready", 32'(req_ready), 32'h0);
        chk("t1_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t1_rst_op_count",  32'(op_count),  32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t1_first_grant", 32'(req_ready), 32'h1);

        for (int k = 0; k < 6; k++) begin
            step();
            chk("t4_rr_id", 32'(rsp_id), 32'(seq1[k]));
        end

        // Asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t6_op_count",  32'(op_count),  32'h0);
        chk("t6_rsp_data",  32'(rsp_data),  32'h0);
        chk("t6_req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b1011;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_drop2_id", 32'(rsp_id), 32'(seq2[k]));
        end
        chk("t6_count_after", 32'(op_count), 32'd4);

        // Op sweep on requester 0
        req_valid = 4'b0001;
        req_a[WIDTH-1:0] = 8'hA5;
        req_b[WIDTH-1:0] = 8'h3C;
        for (int k = 0; k < 7; k++) begin
            req_op[2:0] = 3'(k);
            step();
            chk("t2_sweep_data", 32'(rsp_data), 32'(sweep[k]));
            chk("t2_sweep_id",   32'(rsp_id),   32'h0);
        end

        // Illegal op then a legal one
        req_op[2:0] = 3'd7;
        step();
        chk("t3_err",   32'(rsp_err),  32'h1);
        chk("t3_data",  32'(rsp_data), 32'h0);
        chk("t3_count", 32'(op_count), 32'd12);
        req_op[2:0] = 3'd0;
        step();
        chk("t3_next_err",  32'(rsp_err),  32'h0);
        chk("t3_next_data", 32'(rsp_data), 32'hBD);

        // Backpressure with a new request waiting
        rsp_ready   = 1'b0;
        req_op[2:0] = 3'd2;
        #1;
        chk("t5_stall_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_hold_data",  32'(rsp_data),  32'hBD);
            chk("t5_hold_valid", 32'(rsp_valid), 32'h1);
            chk("t5_hold_ready", 32'(req_ready), 32'h0);
            chk("t5_hold_count", 32'(op_count),  32'd13);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_release_ready", 32'(req_ready), 32'h1);
        step();
        chk("t5_no_bubble_data",  32'(rsp_data), 32'h99);
        chk("t5_no_bubble_count", 32'(op_count), 32'd14);

        // Counter saturation
        while (op_count != 16'hFFFE && guard < 70000) begin
            step();
            guard++;
        end
        chk("sat_reach_fffe", 32'(op_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sat_hold_ffff", 32'(op_count), 32'hFFFF);
        end
        req_valid = '0;
        step();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_count", 32'(op_count),  32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
